// File: rtl/sram_uart_interface_pkg.sv
// State definitions shared by the SRAM-to-UART streamer and its serializer.
package sram_uart_interface_pkg;

  typedef enum logic [3:0] {
    S_SU_IDLE,
    S_SU_READ,
    S_SU_WAIT_1,
    S_SU_CAPTURE,
    S_SU_SEND_HI,
    S_SU_WAIT_HI,
    S_SU_SEND_LO,
    S_SU_WAIT_LO,
    S_SU_NEXT
  } SRAM_UART_state_type;

  typedef enum logic {
    S_TX_IDLE,
    S_TX_SEND
  } UART_TX_state_type;

  localparam logic [17:0] SRAM_ADDR_MAX = 18'h3FFFF;

endpackage

// File: rtl/sram_uart_interface_tx.sv
// 8N1 UART serializer: start bit, 8 data bits LSB first, stop bit.
module UART_Transmit_Controller
  import sram_uart_interface_pkg::*;
#(
  parameter int CLK_PER_BIT = 434
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Load,
  input  logic [7:0] TX_data,
  output logic       Ready,
  output logic       UART_TX_O
);

  localparam int BAUD_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);

  UART_TX_state_type state_reg, state_next;
  logic [BAUD_W-1:0] baud_cnt_reg, baud_cnt_next;
  logic [3:0]        bit_idx_reg, bit_idx_next;
  logic [7:0]        data_reg, data_next;
  logic              tx_reg, tx_next;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_reg    <= S_TX_IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= 4'd0;
      data_reg     <= 8'd0;
      tx_reg       <= 1'b1;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      data_reg     <= data_next;
      tx_reg       <= tx_next;
    end
  end

  // bit_idx 0 is the start bit, 1..8 the data bits, 9 the stop bit
  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_idx_next  = bit_idx_reg;
    data_next     = data_reg;
    tx_next       = tx_reg;
    case (state_reg)
      S_TX_IDLE: begin
        if (Load) begin
          state_next    = S_TX_SEND;
          data_next     = TX_data;
          baud_cnt_next = '0;
          bit_idx_next  = 4'd0;
          tx_next       = 1'b0;
        end
      end
      S_TX_SEND: begin
        if (baud_cnt_reg == BAUD_LAST) begin
          baud_cnt_next = '0;
          if (bit_idx_reg == 4'd9) begin
            state_next   = S_TX_IDLE;
            bit_idx_next = 4'd0;
            tx_next      = 1'b1;
          end else begin
            bit_idx_next = bit_idx_reg + 4'd1;
            tx_next      = (bit_idx_reg == 4'd8) ? 1'b1 : data_reg[bit_idx_reg[2:0]];
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      default: state_next = S_TX_IDLE;
    endcase
  end

  assign Ready     = (state_reg == S_TX_IDLE);
  assign UART_TX_O = tx_reg;

endmodule

// File: rtl/sram_uart_interface.sv
// Streams an inclusive SRAM word range out over UART, high byte first.
module sram_uart_interface
  import sram_uart_interface_pkg::*;
#(
  parameter int CLK_PER_BIT = 434
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Initialize,
  input  logic        Start,
  input  logic [17:0] Start_address,
  input  logic [17:0] End_address,
  output logic [17:0] SRAM_address,
  input  logic [15:0] SRAM_read_data,
  output logic        SRAM_we_n,
  output logic        UART_TX_O,
  output logic        Busy,
  output logic        Done
);

  SRAM_UART_state_type state_reg, state_next;
  logic [17:0] addr_reg, addr_next;
  logic [17:0] end_addr_reg, end_addr_next;
  logic [15:0] word_reg, word_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        tx_resetn_reg;
  logic        tx_load;
  logic [7:0]  tx_data;
  logic        tx_ready;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_reg    <= S_SU_IDLE;
      addr_reg     <= 18'd0;
      end_addr_reg <= 18'd0;
      word_reg     <= 16'd0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      end_addr_reg <= end_addr_next;
      word_reg     <= word_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  // Registered abort: Initialize clears the serializer from a flop, so the
  // line returns high right after the edge that samples Initialize.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) tx_resetn_reg <= 1'b0;
    else         tx_resetn_reg <= ~Initialize;
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    end_addr_next = end_addr_reg;
    word_next     = word_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    tx_load       = 1'b0;
    tx_data       = word_reg[15:8];
    if (Initialize) begin
      state_next = S_SU_IDLE;
      busy_next  = 1'b0;
    end else begin
      case (state_reg)
        S_SU_IDLE: begin
          if (Start) begin
            addr_next     = Start_address;
            end_addr_next = End_address;
            busy_next     = 1'b1;
            state_next    = S_SU_READ;
          end
        end
        S_SU_READ:    state_next = S_SU_WAIT_1;
        S_SU_WAIT_1:  state_next = S_SU_CAPTURE;
        S_SU_CAPTURE: begin
          word_next  = SRAM_read_data;
          state_next = S_SU_SEND_HI;
        end
        S_SU_SEND_HI: begin
          if (tx_ready) begin
            tx_load    = 1'b1;
            state_next = S_SU_WAIT_HI;
          end
        end
        S_SU_WAIT_HI: if (tx_ready) state_next = S_SU_SEND_LO;
        S_SU_SEND_LO: begin
          tx_data = word_reg[7:0];
          if (tx_ready) begin
            tx_load    = 1'b1;
            state_next = S_SU_WAIT_LO;
          end
        end
        S_SU_WAIT_LO: if (tx_ready) state_next = S_SU_NEXT;
        S_SU_NEXT: begin
          // >= also ends a reversed range after its first word
          if (addr_reg >= end_addr_reg || addr_reg == SRAM_ADDR_MAX) begin
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = S_SU_IDLE;
          end else begin
            addr_next  = addr_reg + 18'd1;
            state_next = S_SU_READ;
          end
        end
        default: state_next = S_SU_IDLE;
      endcase
    end
  end

  UART_Transmit_Controller #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_tx (
    .Clock    (Clock),
    .Resetn   (tx_resetn_reg),
    .Load     (tx_load),
    .TX_data  (tx_data),
    .Ready    (tx_ready),
    .UART_TX_O(UART_TX_O)
  );

  assign SRAM_address = addr_reg;
  assign SRAM_we_n    = 1'b1;
  assign Busy         = busy_reg;
  assign Done         = done_reg;

endmodule

// File: doc/sram_uart_interface.md
SRAM_UART_INTERFACE -- requirements
Module: sram_uart_interface

Interface
REQ-001 Parameter CLK_PER_BIT, default 434, Clock cycles per UART bit (50 MHz / 115200 baud).
REQ-002 Clock  input  1  system clock, all state updates on rising edge.
REQ-003 Resetn  input  1  reset, asynchronous, active-low.
REQ-004 Initialize  input  1  synchronous abort, highest priority after Resetn.
REQ-005 Start  input  1  single-cycle request to begin a transfer, honoured only in S_SU_IDLE.
REQ-006 Start_address  input  18  first SRAM word address, sampled when Start is accepted.
REQ-007 End_address  input  18  last SRAM word address (inclusive), sampled when Start is accepted.
REQ-008 SRAM_address  output  18  SRAM word address.
REQ-009 SRAM_read_data  input  16  SRAM read data, valid 2 cycles after SRAM_address is presented.
REQ-010 SRAM_we_n  output  1  SRAM write enable, constant 1 (read-only block).
REQ-011 UART_TX_O  output  1  serial line, idle high.
REQ-012 Busy  output  1  high from Start acceptance until return to S_SU_IDLE.
REQ-013 Done  output  1  one-cycle pulse on normal completion.

Function
REQ-014 Each word is sent as two UART frames: SRAM_read_data[15:8] first, then [7:0].
REQ-015 Frame format: one start bit (0), 8 data bits LSB first, one stop bit (1), each bit CLK_PER_BIT cycles, 10*CLK_PER_BIT cycles per frame.
REQ-016 FSM states: S_SU_IDLE, S_SU_READ, S_SU_WAIT_1, S_SU_CAPTURE, S_SU_SEND_HI, S_SU_WAIT_HI, S_SU_SEND_LO, S_SU_WAIT_LO, S_SU_NEXT.
REQ-017 S_SU_IDLE: on Start, SRAM_address <= Start_address, latch End_address, Busy <= 1, go to S_SU_READ.
REQ-018 S_SU_READ -> S_SU_WAIT_1 -> S_SU_CAPTURE, one cycle each; S_SU_CAPTURE latches SRAM_read_data into a 16-bit word register.
REQ-019 S_SU_SEND_HI: when transmitter Ready = 1, pulse Load for one cycle with the high byte, go to S_SU_WAIT_HI.
REQ-020 S_SU_WAIT_HI: wait until Ready returns to 1, go to S_SU_SEND_LO; S_SU_SEND_LO / S_SU_WAIT_LO behave the same for the low byte.
REQ-021 S_SU_NEXT: if SRAM_address == latched end address or SRAM_address == 18'h3FFFF, pulse Done, Busy <= 0, go to S_SU_IDLE; otherwise SRAM_address + 1, go to S_SU_READ.
REQ-022 Start_address > End_address sends exactly one word (Start_address) and then completes; the address never wraps past 18'h3FFFF.
REQ-023 Start while Busy = 1 is ignored.
REQ-024 Back-to-back frames: the next frame's start bit follows the previous stop bit with no more than 4 idle cycles, excluding SRAM read cycles between words.
REQ-025 Initialize = 1: FSM -> S_SU_IDLE, Busy = 0, no Done pulse, transmitter aborted, UART_TX_O driven 1 on the next cycle; a partial frame is truncated.
REQ-026 Start and Initialize asserted in the same cycle: Initialize wins and the Start is dropped.

Reset
REQ-027 On Resetn = 0, outputs take these values: SRAM_address = 0, SRAM_we_n = 1, UART_TX_O = 1, Busy = 0, Done = 0.
REQ-028 On Resetn = 0, internal state takes these values: FSM = S_SU_IDLE, word register = 0, bit counter = 0, baud counter = 0.

Structure
REQ-029 The state enum type SRAM_UART_state_type is added to the shared state-definition header alongside the existing UART/SRAM state types.
REQ-030 The transmitter-side state enum is added to the same shared header.
REQ-031 One sub-module, UART_Transmit_Controller, implements the serializer.
REQ-032 UART_Transmit_Controller ports: Clock, Resetn, Load, TX_data[7:0], Ready, UART_TX_O.
REQ-033 UART_Transmit_Controller counters: a baud counter with CLK_PER_BIT terminal count and a 4-bit bit index.
REQ-034 In UART_Transmit_Controller, Ready = 1 only when idle; Load while Ready = 0 is ignored.

Verification
REQ-035 Start_address = 0, End_address = 0, SRAM[0] = 16'hA55A: bench decodes bytes 8'hA5 then 8'h5A, Done pulses once, Busy low afterwards.
REQ-036 Start_address = 10, End_address = 13, words 16'h0102/0304/0506/0708: bench decodes 8 bytes 01..08 in order, 4 SRAM reads at addresses 10..13.
REQ-037 Frame timing, CLK_PER_BIT = 16, byte 8'h80: line low 16 cycles (start), 7 low data bits, 1 high bit, 1 high stop bit, 160 cycles total.
REQ-038 Start_address = 18'h3FFFE, End_address = 18'h3FFFF: exactly 2 words sent, final SRAM_address = 18'h3FFFF, no wrap to 0.
REQ-039 Initialize asserted mid-frame of the second byte: UART_TX_O = 1 the next cycle, Busy = 0, no Done pulse; a new Start then completes normally.
REQ-040 Start pulsed while Busy with Start_address = 99: ignored, the original transfer sends unchanged bytes, SRAM_address is never 99.
